// File: rtl/ecg_bit_funnel.sv
// ecg_bit_funnel: bitstream funnel that feeds the ECG/suffix parser.
// It collects packed words from the rate buffer into an MSB-aligned bit buffer.
// It presents the top WIN_W bits as the parser window.
// The window advances each cycle by the parser's numbits result.
// Optional feature macro: VDCM_FUNNEL_BITCNT_EN adds a bit_count output that
// totals the bits consumed since the last rst/slice_start.
module ecg_bit_funnel #(
  parameter int DATA_W = 64,
  parameter int WIN_W  = 128,
  parameter int BUF_W  = 256,
  parameter int LVL_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slice_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              consume_en,
  input  logic [7:0]        consume_bits,
  output logic              win_valid,
  output logic [WIN_W-1:0]  win_data,
  output logic [LVL_W-1:0]  level,
  output logic              err_underrun,
  output logic              err_overrun
`ifdef VDCM_FUNNEL_BITCNT_EN
  ,
  output logic [31:0]       bit_count
`endif
);

  localparam logic [LVL_W-1:0] WIN_LVL   = LVL_W'(WIN_W);
  localparam logic [LVL_W-1:0] DATA_LVL  = LVL_W'(DATA_W);
  localparam logic [LVL_W-1:0] READY_MAX = LVL_W'(BUF_W - DATA_W);

  logic [BUF_W-1:0] bit_buf;
  logic [LVL_W-1:0] level_q;
  logic             err_underrun_q;
  logic             err_overrun_q;

  logic [BUF_W-1:0] buf_next;
  logic [LVL_W-1:0] level_next;
  logic [LVL_W-1:0] bits_lvl;
  logic [LVL_W-1:0] shift_amt;
  logic [LVL_W-1:0] remain;
  logic [BUF_W-1:0] word_ext;
  logic             accept;
  logic             too_big;
  logic             consume;
  logic             underrun_hit;
  logic             overrun_hit;

  // Outputs come straight from registers so that in_ready has no path from consume_en.
  always_comb begin
    win_valid    = (level_q >= WIN_LVL);
    in_ready     = (level_q <= READY_MAX);
    win_data     = bit_buf[BUF_W-1 -: WIN_W];
    level        = level_q;
    err_underrun = err_underrun_q;
    err_overrun  = err_overrun_q;
  end

  // Next buffer contents: drop the consumed bits, then OR the new word in just below the survivors.
  always_comb begin
    accept       = in_valid & in_ready;
    bits_lvl     = LVL_W'(consume_bits);
    too_big      = (bits_lvl > WIN_LVL);
    underrun_hit = consume_en & ~win_valid;
    overrun_hit  = consume_en & too_big;
    consume      = consume_en & win_valid & ~too_big;
    shift_amt    = consume ? bits_lvl : '0;
    remain       = level_q - shift_amt;
    word_ext     = {in_data, {(BUF_W-DATA_W){1'b0}}};
    buf_next     = bit_buf << shift_amt;
    level_next   = remain;
    if (accept) begin
      buf_next   = buf_next | (word_ext >> remain);
      level_next = remain + DATA_LVL;
    end
  end

  // State register; rst and slice_start both empty the buffer and drop same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst || slice_start) begin
      bit_buf        <= '0;
      level_q        <= '0;
      err_underrun_q <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      bit_buf        <= buf_next;
      level_q        <= level_next;
      err_underrun_q <= err_underrun_q | underrun_hit;
      err_overrun_q  <= err_overrun_q | overrun_hit;
    end
  end

`ifdef VDCM_FUNNEL_BITCNT_EN
  logic [31:0] bit_cnt_q;

  assign bit_count = bit_cnt_q;

  // Running total of legally consumed bits, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst || slice_start) begin
      bit_cnt_q <= '0;
    end else if (consume) begin
      bit_cnt_q <= bit_cnt_q + 32'(consume_bits);
    end
  end
`endif

endmodule

// File: tb/tb_ecg_bit_funnel.sv
// tb_ecg_bit_funnel: directed scoreboard bench for ecg_bit_funnel.
// Define VDCM_FUNNEL_BITCNT_EN to also check bit_count.
module tb_ecg_bit_funnel;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         slice_start = 1'b0;
  logic         in_valid = 1'b0;
  logic [63:0]  in_data = '0;
  logic         in_ready;
  logic         consume_en = 1'b0;
  logic [7:0]   consume_bits = '0;
  logic         win_valid;
  logic [127:0] win_data;
  logic [8:0]   level;
  logic         err_underrun;
  logic         err_overrun;
`ifdef VDCM_FUNNEL_BITCNT_EN
  logic [31:0]  bit_count;
`endif

  ecg_bit_funnel dut (
    .clk          (clk),
    .rst          (rst),
    .slice_start  (slice_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .consume_en   (consume_en),
    .consume_bits (consume_bits),
    .win_valid    (win_valid),
    .win_data     (win_data),
    .level        (level),
    .err_underrun (err_underrun),
    .err_overrun  (err_overrun)
`ifdef VDCM_FUNNEL_BITCNT_EN
    ,
    .bit_count    (bit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           tgt;
    string        name;
    logic [8:0]   lvl;
    logic         wv;
    logic [127:0] wd;
    logic         ir;
    logic         eu;
    logic         eo;
    logic [31:0]  bc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [63:0]  w [5];
  logic [191:0] s3;
  logic [255:0] s4;

  // Cycle counter used to tag when each expectation becomes due.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input string n, input int lvl, input logic [127:0] wd,
                              input logic ir, input logic eu, input logic eo,
                              input logic [31:0] bc);
    exp_t e;
    e.tgt  = 0;
    e.name = n;
    e.lvl  = 9'(lvl);
    e.wv   = (lvl >= 128);
    e.wd   = wd;
    e.ir   = ir;
    e.eu   = eu;
    e.eo   = eo;
    e.bc   = bc;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic ok;
    tests++;
    ok = (level == e.lvl) && (win_valid == e.wv) && (win_data == e.wd) &&
         (in_ready == e.ir) && (err_underrun == e.eu) && (err_overrun == e.eo);
`ifdef VDCM_FUNNEL_BITCNT_EN
    ok = ok && (bit_count == e.bc);
    if (!ok)
      $display("[TB] FAIL %s: bit_count got %0d want %0d", e.name, bit_count, e.bc);
`endif
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s: got lvl=%0d wv=%0b ir=%0b eu=%0b eo=%0b wd=%h; want lvl=%0d wv=%0b ir=%0b eu=%0b eo=%0b wd=%h",
               e.name, level, win_valid, in_ready, err_underrun, err_overrun, win_data,
               e.lvl, e.wv, e.ir, e.eu, e.eo, e.wd);
    end
  endtask

  // Monitor: compares every expectation that falls due on this cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      if (sb[0].tgt < cyc) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s: check missed, due cycle %0d at cycle %0d", sb[0].name, sb[0].tgt, cyc);
        void'(sb.pop_front());
      end else begin
        checkOutput(sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input exp_t e, input logic r, input logic ss, input logic iv,
                               input logic [63:0] d, input logic ce, input logic [7:0] cb);
    exp_t q;
    rst          = r;
    slice_start  = ss;
    in_valid     = iv;
    in_data      = d;
    consume_en   = ce;
    consume_bits = cb;
    q            = e;
    q.tgt        = cyc + 1;
    sb.push_back(q);
    @(posedge clk);
    #1;
  endtask

  initial begin
    w[0] = 64'hFEDC_BA98_7654_3210;
    w[1] = 64'h0123_4567_89AB_CDEF;
    w[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    w[3] = 64'h1111_2222_3333_4444;
    w[4] = 64'h0F1E_2D3C_4B5A_6978;
    s3   = {w[0], w[1], w[2]};
    s4   = {w[0], w[1], w[2], w[3]};
    #1;

    // reset and fill
    applyStimulus(mk("reset", 0, '0, 1, 0, 0, 0), 1, 0, 0, '0, 0, 0);
    applyStimulus(mk("fill1", 64, {w[0], 64'h0}, 1, 0, 0, 0), 0, 0, 1, w[0], 0, 0);
    applyStimulus(mk("fill2", 128, {w[0], w[1]}, 1, 0, 0, 0), 0, 0, 1, w[1], 0, 0);
    applyStimulus(mk("fill3", 192, {w[0], w[1]}, 1, 0, 0, 0), 0, 0, 1, w[2], 0, 0);
    applyStimulus(mk("consume1", 191, s3[190 -: 128], 1, 0, 0, 1), 0, 0, 0, '0, 1, 8'd1);
    applyStimulus(mk("slice1", 0, '0, 1, 0, 0, 0), 0, 1, 0, '0, 0, 0);

    // refill to 192, then accept and consume together
    applyStimulus(mk("refill1", 64, {w[0], 64'h0}, 1, 0, 0, 0), 0, 0, 1, w[0], 0, 0);
    applyStimulus(mk("refill2", 128, {w[0], w[1]}, 1, 0, 0, 0), 0, 0, 1, w[1], 0, 0);
    applyStimulus(mk("refill3", 192, {w[0], w[1]}, 1, 0, 0, 0), 0, 0, 1, w[2], 0, 0);
    applyStimulus(mk("acc_cons24", 232, s4[231 -: 128], 0, 0, 0, 24), 0, 0, 1, w[3], 1, 8'd24);

    // full: input offered but refused
    applyStimulus(mk("full_cons32", 200, s4[199 -: 128], 0, 0, 0, 56), 0, 0, 1, w[4], 1, 8'd32);
    applyStimulus(mk("full_hold", 200, s4[199 -: 128], 0, 0, 0, 56), 0, 0, 1, w[4], 0, 0);
    applyStimulus(mk("cons128", 72, {s4[71:0], 56'h0}, 1, 0, 0, 184), 0, 0, 1, w[4], 1, 8'd128);

    // errors
    applyStimulus(mk("underrun_acc", 136, {s4[71:0], w[4][63:8]}, 1, 1, 0, 184), 0, 0, 1, w[4], 1, 8'd5);
    applyStimulus(mk("overrun", 136, {s4[71:0], w[4][63:8]}, 1, 1, 1, 184), 0, 0, 0, '0, 1, 8'd129);
    applyStimulus(mk("cons0", 136, {s4[71:0], w[4][63:8]}, 1, 1, 1, 184), 0, 0, 0, '0, 1, 8'd0);
    applyStimulus(mk("slice_clr", 0, '0, 1, 0, 0, 0), 0, 1, 1, w[0], 1, 8'd8);

    // bit count sequence
    applyStimulus(mk("bc_fill1", 64, {w[0], 64'h0}, 1, 0, 0, 0), 0, 0, 1, w[0], 0, 0);
    applyStimulus(mk("bc_fill2", 128, {w[0], w[1]}, 1, 0, 0, 0), 0, 0, 1, w[1], 0, 0);
    applyStimulus(mk("bc_fill3", 192, {w[0], w[1]}, 1, 0, 0, 0), 0, 0, 1, w[2], 0, 0);
    applyStimulus(mk("bc_cons9", 183, s3[182 -: 128], 1, 0, 0, 9), 0, 0, 0, '0, 1, 8'd9);
    applyStimulus(mk("bc_cons17", 166, s3[165 -: 128], 1, 0, 0, 26), 0, 0, 0, '0, 1, 8'd17);
    applyStimulus(mk("bc_cons1", 165, s3[164 -: 128], 1, 0, 0, 27), 0, 0, 0, '0, 1, 8'd1);
    applyStimulus(mk("bc_slice", 0, '0, 1, 0, 0, 0), 0, 1, 0, '0, 0, 0);

    // reset mid-stream drops buffered data and the same-cycle word
    applyStimulus(mk("post_fill", 64, {w[3], 64'h0}, 1, 0, 0, 0), 0, 0, 1, w[3], 0, 0);
    applyStimulus(mk("mid_reset", 0, '0, 1, 0, 0, 0), 1, 0, 1, w[0], 1, 8'd4);

    rst = 0; slice_start = 0; in_valid = 0; consume_en = 0; consume_bits = '0;
    repeat (3) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: expectation never checked", sb[0].name);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
